// File: rtl/fetch_unit_pkg.sv
// Shared constants for the BRISC-V fetch stage: next-PC select codes,
// FSM state encoding and the NOP word presented after reset.
package fetch_unit_pkg;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JAL    = 2'b10;
  localparam logic [1:0] SEL_JALR   = 2'b11;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_next_pc_select.sv
// Combinational next-PC mux: picks the target, clears JALR bit 0, then
// forces word alignment and flags when any low bits had to be dropped.
module next_pc_select
  import fetch_unit_pkg::*;
#(
  parameter int ADDRESS_BITS = 32
) (
  input  logic [ADDRESS_BITS-1:0] pc,
  input  logic [1:0]              select,
  input  logic [ADDRESS_BITS-1:0] branch_target,
  input  logic [ADDRESS_BITS-1:0] JAL_target,
  input  logic [ADDRESS_BITS-1:0] JALR_target,
  output logic [ADDRESS_BITS-1:0] next_pc,
  output logic                    misaligned
);

  logic [ADDRESS_BITS-1:0] raw_pc;

  always_comb begin
    raw_pc = pc + ADDRESS_BITS'(4);
    case (select)
      SEL_BRANCH: raw_pc = branch_target;
      SEL_JAL:    raw_pc = JAL_target;
      SEL_JALR:   raw_pc = {JALR_target[ADDRESS_BITS-1:1], 1'b0};
      default:    raw_pc = pc + ADDRESS_BITS'(4);
    endcase
  end

  assign next_pc    = {raw_pc[ADDRESS_BITS-1:2], 2'b00};
  assign misaligned = |raw_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one instruction-memory request
// at a time and holds the fetched word for decode until the core advances.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                    CORE         = 0,
  parameter int                    ADDRESS_BITS = 32,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    advance,
  input  logic [1:0]              next_PC_select,
  input  logic [ADDRESS_BITS-1:0] branch_target,
  input  logic [ADDRESS_BITS-1:0] JAL_target,
  input  logic [ADDRESS_BITS-1:0] JALR_target,
  input  logic                    i_mem_ready,
  input  logic                    i_mem_valid,
  input  logic [31:0]             i_mem_data,
  output logic                    i_mem_read,
  output logic [ADDRESS_BITS-1:0] i_mem_addr,
  output logic [ADDRESS_BITS-1:0] PC,
  output logic [31:0]             instruction,
  output logic                    instr_valid,
  output logic                    misaligned,
  output logic [31:0]             fetch_count,
  input  logic                    report
);

  fetch_state_t            state;
  logic [ADDRESS_BITS-1:0] fetch_pc;
  logic [ADDRESS_BITS-1:0] sel_pc;
  logic                    sel_misaligned;

  // report/CORE only drive simulation messages, which this RTL does not emit.
  logic unused_ok;
  assign unused_ok = &{1'b0, report, CORE[0]};

  next_pc_select #(
    .ADDRESS_BITS(ADDRESS_BITS)
  ) u_next_pc_select (
    .pc           (fetch_pc),
    .select       (next_PC_select),
    .branch_target(branch_target),
    .JAL_target   (JAL_target),
    .JALR_target  (JALR_target),
    .next_pc      (sel_pc),
    .misaligned   (sel_misaligned)
  );

  assign i_mem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      PC          <= RESET_PC;
      instruction <= NOP;
      instr_valid <= 1'b0;
      i_mem_read  <= 1'b0;
      misaligned  <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          state      <= REQ;
          i_mem_read <= 1'b1;
        end
        REQ: begin
          if (i_mem_ready) begin
            state      <= WAIT;
            i_mem_read <= 1'b0;
          end
        end
        // Responses are only accepted here; anything arriving elsewhere is stale.
        WAIT: begin
          if (i_mem_valid) begin
            instruction <= i_mem_data;
            PC          <= fetch_pc;
            instr_valid <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (advance) begin
            fetch_pc    <= sel_pc;
            misaligned  <= sel_misaligned;
            instr_valid <= 1'b0;
            i_mem_read  <= 1'b1;
            state       <= REQ;
          end
        end
        default: begin
          state      <= IDLE;
          i_mem_read <= 1'b0;
        end
      endcase
    end
  end

endmodule
